// File: rtl/melody_pkg.sv
// Shared constants for the melody sequencer: note codes, the 50 MHz pitch table and FSM states.
package melody_pkg;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_C    = 4'd1;
  localparam logic [3:0] NOTE_CS   = 4'd2;
  localparam logic [3:0] NOTE_D    = 4'd3;
  localparam logic [3:0] NOTE_DS   = 4'd4;
  localparam logic [3:0] NOTE_E    = 4'd5;
  localparam logic [3:0] NOTE_F    = 4'd6;
  localparam logic [3:0] NOTE_FS   = 4'd7;
  localparam logic [3:0] NOTE_G    = 4'd8;
  localparam logic [3:0] NOTE_GS   = 4'd9;
  localparam logic [3:0] NOTE_A    = 4'd10;
  localparam logic [3:0] NOTE_AS   = 4'd11;
  localparam logic [3:0] NOTE_B    = 4'd12;

  // Index 0 is C5 (note code 1); values are clk cycles per half period at 50 MHz.
  typedef logic [11:0][19:0] hp_tab_t;
  localparam hp_tab_t HP_BASE_50M = {
    20'd25_308, 20'd26_813, 20'd28_408, 20'd30_096, 20'd31_887, 20'd33_784,
    20'd35_793, 20'd37_922, 20'd40_177, 20'd42_566, 20'd45_097, 20'd47_778
  };

  typedef enum logic [2:0] {ST_IDLE, ST_PLAY, ST_GAP, ST_NEXT, ST_END} state_e;

  function automatic logic is_tone(input logic [3:0] n);
    return (n != NOTE_REST) && (n <= NOTE_B);
  endfunction

endpackage

// File: rtl/melody_player_tone.sv
// Half-period counter and square-wave flop; clr or a silent note forces the output low.
module tone_gen #(
  parameter int HP_W = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            clr,
  input  logic [HP_W-1:0] hp,
  output logic            wave
);

  logic [HP_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      wave  <= 1'b0;
    end else if (clr || !en) begin
      cnt_q <= '0;
      wave  <= 1'b0;
    end else if (cnt_q == hp) begin
      cnt_q <= '0;
      wave  <= ~wave;
    end else begin
      cnt_q <= cnt_q + HP_W'(1);
    end
  end

endmodule

// File: rtl/melody_player.sv
// Note-table melody sequencer driving the buzzer. Define MELODY_REPEAT_EN to loop
// the song while play stays high at the end of the table.
module melody_player
  import melody_pkg::*;
#(
  parameter int      DEPTH       = 16,
  parameter int      DUR_W       = 8,
  parameter int      HP_W        = 20,
  parameter int      TICK_CYCLES = 5_000_000,
  parameter int      GAP_TICKS   = 0,
  parameter hp_tab_t HP_TAB      = HP_BASE_50M
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     play,
  input  logic                     stop,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [6+DUR_W-1:0]       wr_data,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] note_idx,
  output logic                     melody
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 6 + DUR_W;
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int GW = $clog2(GAP_TICKS + 1);
  localparam int CW = (DUR_W > GW) ? DUR_W : GW;

  logic [EW-1:0]   tab_q [DEPTH];
  state_e          state_q;
  logic            play_q, busy_q, done_q;
  logic [AW-1:0]   idx_q, idx_inc;
  logic [TW-1:0]   tick_q;
  logic [CW-1:0]   cnt_q, tgt;
  logic [EW-1:0]   cur;
  logic [3:0]      cur_note, hp_sel;
  logic [HP_W-1:0] hp_eff;
  logic            rise, first_ok, nxt_end, rpt, tick_last, phase_end, tone_clr;

  // NEXT and END are resolved here in zero time, on the edge that ends a note or gap.
  always_comb begin
    cur       = tab_q[idx_q];
    cur_note  = cur[EW-1 -: 4];
    hp_sel    = is_tone(cur_note) ? cur_note - 4'd1 : 4'd0;
    hp_eff    = ((HP_W'(HP_TAB[hp_sel]) + HP_W'(1)) << cur[DUR_W +: 2]) - HP_W'(1);
    rise      = play & ~play_q;
    idx_inc   = idx_q + AW'(1);
    first_ok  = tab_q[0][DUR_W-1:0] != '0;
    nxt_end   = (idx_q == AW'(DEPTH - 1)) || (tab_q[idx_inc][DUR_W-1:0] == '0);
`ifdef MELODY_REPEAT_EN
    rpt       = play && first_ok;
`else
    rpt       = 1'b0;
`endif
    tgt       = (state_q == ST_GAP) ? CW'(GAP_TICKS) : CW'(cur[DUR_W-1:0]);
    tick_last = tick_q == TW'(TICK_CYCLES - 1);
    phase_end = tick_last && (cnt_q + CW'(1) == tgt);
    tone_clr  = stop || (state_q != ST_PLAY) || phase_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) tab_q[i] <= '0;
      state_q <= ST_IDLE;
      play_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      tick_q  <= '0;
      cnt_q   <= '0;
    end else begin
      play_q <= play;
      done_q <= 1'b0;
      if (wr_en && !busy_q) tab_q[wr_addr] <= wr_data;
      if (stop) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: if (rise) begin
            idx_q  <= '0;
            tick_q <= '0;
            cnt_q  <= '0;
            if (first_ok) begin
              state_q <= ST_PLAY;
              busy_q  <= 1'b1;
            end else begin
              done_q  <= 1'b1;
            end
          end
          ST_PLAY, ST_GAP: begin
            if (!phase_end) begin
              tick_q <= tick_last ? '0 : tick_q + TW'(1);
              if (tick_last) cnt_q <= cnt_q + CW'(1);
            end else begin
              tick_q <= '0;
              cnt_q  <= '0;
              if (state_q == ST_PLAY && GAP_TICKS > 0) begin
                state_q <= ST_GAP;
              end else if (!nxt_end) begin
                idx_q   <= idx_inc;
                state_q <= ST_PLAY;
              end else if (rpt) begin
                idx_q   <= '0;
                state_q <= ST_PLAY;
              end else begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  tone_gen #(.HP_W(HP_W)) u_tone (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (is_tone(cur_note)),
    .clr  (tone_clr),
    .hp   (hp_eff),
    .wave (melody)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign note_idx = idx_q;

endmodule
